// File: rtl/hs_npu_mm_ctrl.sv
// Matrix-multiply sequencer for the NPU systolic array: flushes, loads weights,
// and times the input/output gatekeeper starts and the completion pulse.
module hs_npu_mm_ctrl #(
  parameter int SIZE      = 8,
  parameter int OUT_DELAY = SIZE + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_rows_i,
  input  logic        cmd_reuse_w_i,
  input  logic        abort_i,
  input  logic        wt_avail_i,
  input  logic        in_avail_i,
  output logic        flush_input_fifos_o,
  output logic        flush_weight_fifos_o,
  output logic        enable_weights_o,
  output logic        start_input_gatekeeper_o,
  output logic        start_output_gatekeeper_o,
  output logic [31:0] enable_cycles_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    IDLE, FLUSH, LOAD_W, WAIT_IN, STREAM, DRAIN, DONE
  } state_t;

  localparam logic [31:0] SIZE_W = 32'(SIZE);
  localparam logic [31:0] ODLY_W = 32'(OUT_DELAY);

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] rows_q, rows_n;
  logic        reuse_q, reuse_n;
  logic        abort_q, abort_n;
  logic        fi_n, fw_n, ew_n, si_n, so_n, done_n;

  // Outputs are registered, so every decision is made one cycle ahead
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rows_n  = rows_q;
    reuse_n = reuse_q;
    abort_n = 1'b0;
    fi_n    = 1'b0;
    fw_n    = 1'b0;
    ew_n    = 1'b0;
    si_n    = 1'b0;
    so_n    = 1'b0;
    done_n  = 1'b0;
    if (state != IDLE && abort_i && !abort_q) begin
      cnt_n = '0;
      if (state == FLUSH) begin
        state_n = IDLE;
      end else begin
        state_n = FLUSH;
        abort_n = 1'b1;
        fi_n    = 1'b1;
        fw_n    = 1'b1;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            rows_n  = cmd_rows_i;
            reuse_n = cmd_reuse_w_i;
            state_n = FLUSH;
            fi_n    = 1'b1;
            fw_n    = !cmd_reuse_w_i;
            cnt_n   = '0;
          end
        end
        FLUSH: begin
          if (abort_q) begin
            state_n = IDLE;
          end else if (rows_q == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else if (reuse_q) begin
            state_n = in_avail_i ? STREAM : WAIT_IN;
            si_n    = in_avail_i;
            cnt_n   = in_avail_i ? 32'd1 : 32'd0;
          end else begin
            state_n = LOAD_W;
            ew_n    = wt_avail_i;
            cnt_n   = wt_avail_i ? 32'd1 : 32'd0;
          end
        end
        LOAD_W: begin
          if (!enable_weights_o) begin
            ew_n  = wt_avail_i;
            cnt_n = wt_avail_i ? 32'd1 : 32'd0;
          end else if (cnt == SIZE_W) begin
            state_n = in_avail_i ? STREAM : WAIT_IN;
            si_n    = in_avail_i;
            cnt_n   = in_avail_i ? 32'd1 : 32'd0;
          end else begin
            ew_n  = 1'b1;
            cnt_n = cnt + 32'd1;
          end
        end
        WAIT_IN: begin
          state_n = in_avail_i ? STREAM : WAIT_IN;
          si_n    = in_avail_i;
          cnt_n   = in_avail_i ? 32'd1 : 32'd0;
        end
        STREAM: begin
          if (cnt == ODLY_W) begin
            state_n = DRAIN;
            so_n    = 1'b1;
            cnt_n   = 32'd1;
          end else begin
            cnt_n = cnt + 32'd1;
          end
        end
        DRAIN: begin
          if (cnt == rows_q + SIZE_W - 32'd1) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt + 32'd1;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                     <= IDLE;
      cnt                       <= '0;
      rows_q                    <= '0;
      reuse_q                   <= 1'b0;
      abort_q                   <= 1'b0;
      cmd_ready_o               <= 1'b1;
      busy_o                    <= 1'b0;
      enable_cycles_o           <= '0;
      flush_input_fifos_o       <= 1'b0;
      flush_weight_fifos_o      <= 1'b0;
      enable_weights_o          <= 1'b0;
      start_input_gatekeeper_o  <= 1'b0;
      start_output_gatekeeper_o <= 1'b0;
      done_o                    <= 1'b0;
    end else begin
      state                     <= state_n;
      cnt                       <= cnt_n;
      rows_q                    <= rows_n;
      reuse_q                   <= reuse_n;
      abort_q                   <= abort_n;
      cmd_ready_o               <= (state_n == IDLE);
      busy_o                    <= (state_n != IDLE);
      enable_cycles_o           <= (state_n == IDLE) ? 32'd0 : rows_n;
      flush_input_fifos_o       <= fi_n;
      flush_weight_fifos_o      <= fw_n;
      enable_weights_o          <= ew_n;
      start_input_gatekeeper_o  <= si_n;
      start_output_gatekeeper_o <= so_n;
      done_o                    <= done_n;
    end
  end

endmodule

// File: doc/hs_npu_mm_ctrl.md
HS_NPU_MM_CTRL -- requirements
Module: hs_npu_mm_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning systolic array dimension and gatekeeper cascade length.
REQ-002 SHALL have parameter OUT_DELAY, default SIZE+1, meaning cycles from input-gatekeeper start to output-gatekeeper start.
REQ-003 SHALL have ports (clock and reset first), one per line:
- clk  in  1  sole clock; reset is synchronous and active-low
- rst_n  in  1  synchronous active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  controller idle, command accepted on valid&&ready
- cmd_rows_i  in  32  input-matrix rows M for this command (uword)
- cmd_reuse_w_i  in  1  keep previously loaded weights
- abort_i  in  1  cancel current command
- wt_avail_i  in  1  weight FIFOs hold SIZE rows
- in_avail_i  in  1  input FIFOs hold the first row
- flush_input_fifos_o  out  1  to mm unit
- flush_weight_fifos_o  out  1  to mm unit
- enable_weights_o  out  1  to mm unit
- start_input_gatekeeper_o  out  1  one-cycle pulse
- start_output_gatekeeper_o  out  1  one-cycle pulse
- enable_cycles_o  out  32  gatekeeper enable count
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse

Function
REQ-004 SHALL implement states IDLE, FLUSH, LOAD_W, WAIT_IN, STREAM, DRAIN, DONE.
REQ-005 SHALL assert cmd_ready_o only in IDLE; on accept, latch cmd_rows_i and cmd_reuse_w_i, go to FLUSH.
REQ-006 SHALL hold enable_cycles_o at the latched row count from the cycle after accept until return to IDLE; 0 in IDLE.
REQ-007 FLUSH lasts exactly 1 cycle: flush_input_fifos_o=1; flush_weight_fifos_o=1 only if reuse=0.
REQ-008 From FLUSH: if rows==0 go to DONE; else if reuse=1 go to WAIT_IN; else go to LOAD_W.
REQ-009 LOAD_W: wait while wt_avail_i=0, then assert enable_weights_o for exactly SIZE consecutive cycles (counter), then go to WAIT_IN.
REQ-010 enable_weights_o SHALL be 0 outside the SIZE-cycle window of REQ-009.
REQ-011 WAIT_IN: wait while in_avail_i=0; in the first cycle in_avail_i=1, pulse start_input_gatekeeper_o for 1 cycle (cycle T) and go to STREAM.
REQ-012 STREAM: pulse start_output_gatekeeper_o for 1 cycle at exactly T+OUT_DELAY, then go to DRAIN.
REQ-013 DRAIN: count rows+SIZE-1 cycles starting at T+OUT_DELAY, so done_o pulses at T+OUT_DELAY+rows+SIZE-1 (cycle after the last output gatekeeper active cycle).
REQ-014 DONE: done_o=1 for exactly 1 cycle; next state IDLE; cmd_ready_o=1 the cycle after done_o.
REQ-015 Counters SHALL be 32-bit and SHALL NOT wrap for rows up to 2^32-SIZE-OUT_DELAY; larger values are unsupported.
REQ-016 abort_i=1 in any non-IDLE state: next cycle flush_input_fifos_o=1 and flush_weight_fifos_o=1 for 1 cycle, no done_o, no further start pulses, then IDLE.
REQ-017 abort_i in IDLE SHALL be ignored; abort_i has priority over every other transition including DONE.
REQ-018 cmd_valid_i while busy SHALL be ignored (not latched, cmd_ready_o=0).
REQ-019 All outputs SHALL be registered; start, flush and done outputs SHALL never be high for 2 consecutive cycles.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force IDLE, cmd_ready_o=1, all other outputs 0, counters 0, latched command cleared, including mid-operation.
REQ-021 The first command SHALL be acceptable at the first edge after rst_n returns to 1.

Verification
REQ-022 SIZE=8, OUT_DELAY=9, rows=4, reuse=0, wt_avail_i/in_avail_i high -> accept at 0; flushes at 1; enable_weights_o cycles 2-9; start_input at 10; start_output at 19; done_o at 30.
REQ-023 Same command, reuse=1 -> flush_weight_fifos_o stays 0, enable_weights_o never high, start_input at 2, done_o at 22.
REQ-024 wt_avail_i low until cycle 20 -> enable_weights_o cycles 20-27, all later events shifted by 18 relative to REQ-022.
REQ-025 rows=0 -> flushes at 1, done_o at 2, no start or enable_weights pulses.
REQ-026 abort_i at cycle 12 of REQ-022 -> both flushes at 13, start_output never pulses, no done_o, cmd_ready_o=1 at 14.
REQ-027 rst_n=0 at cycle 5 of REQ-022 -> cycle 6: all outputs 0 except cmd_ready_o=1; new command accepted at first edge with rst_n=1.
